// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct/ALU encodings and decode helpers for the exec slice.
package mips_pkg;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   typedef enum logic [2:0] {
      ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_SLT = 3'b111
   } alu_ctl_e;
   typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_e;
   typedef struct packed {
      logic    reg_write;
      logic    reg_dst;
      logic    alu_src;
      logic    branch;
      logic    mem_write;
      logic    mem_to_reg;
      logic    jump;
      alu_op_e alu_op;
   } ctrl_t;
   // Unknown opcodes fall through to all-zero controls, i.e. a no-op with an add ALU.
   function automatic ctrl_t decode(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: c = {7'b1100000, ALUOP_FUNCT};
         OP_LW:    c = {7'b1010010, ALUOP_ADD};
         OP_SW:    c = {7'b0010100, ALUOP_ADD};
         OP_BEQ:   c = {7'b0001000, ALUOP_SUB};
         OP_ADDI:  c = {7'b1010000, ALUOP_ADD};
         OP_J:     c = {7'b0000001, ALUOP_ADD};
         default:  c = '0;
      endcase
      return c;
   endfunction
   function automatic alu_ctl_e funct_ctl(input logic [5:0] fn);
      return fn == FN_SUB ? ALU_SUB :
             fn == FN_AND ? ALU_AND :
             fn == FN_OR  ? ALU_OR  :
             fn == FN_SLT ? ALU_SLT : ALU_ADD;
   endfunction
endpackage

// File: rtl/mips_exec_unit_if.sv
// mips_exec_unit_if: instruction fields and operands in, control/ALU/RAM results out.
interface mips_exec_unit_if;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] src_a;
   logic [31:0] read_data2;
   logic [31:0] imm_ext;
   logic        reg_write, reg_dst, mem_to_reg, branch, jump, alu_src, mem_write;
   logic [2:0]  alu_ctl;
   logic [31:0] alu_out;
   logic        zero;
   logic        pc_src;
   logic [31:0] read_data;
   modport master (
      output opcode, funct, src_a, read_data2, imm_ext,
      input  reg_write, reg_dst, mem_to_reg, branch, jump, alu_src, mem_write,
      input  alu_ctl, alu_out, zero, pc_src, read_data
   );
   modport slave (
      input  opcode, funct, src_a, read_data2, imm_ext,
      output reg_write, reg_dst, mem_to_reg, branch, jump, alu_src, mem_write,
      output alu_ctl, alu_out, zero, pc_src, read_data
   );
endinterface

// File: rtl/mips_data_ram.sv
// mips_data_ram: word RAM with async clear, sync write and combinational read.
module mips_data_ram #(
   parameter int MEM_WORDS = 64,
   localparam int AW = $clog2(MEM_WORDS)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          we_i,
   input  logic [AW-1:0] idx_i,
   input  logic [31:0]   wd_i,
   output logic [31:0]   rd_o
);
   logic [31:0] mem_q [MEM_WORDS];
   always_ff @(posedge clock or posedge reset)
      if (reset)
         for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
      else if (we_i)
         mem_q[idx_i] <= wd_i;
   assign rd_o = mem_q[idx_i];
endmodule

// File: rtl/mips_exec_unit.sv
// mips_exec_unit: single-cycle MIPS decode + ALU + data RAM slice.
module mips_exec_unit
   import mips_pkg::*;
#(
   parameter int MEM_WORDS = 64
) (
   input  logic             clock,
   input  logic             reset,
   mips_exec_unit_if.slave  bus
);
   localparam int AW = $clog2(MEM_WORDS);
   ctrl_t       ctl;
   alu_ctl_e    alu_ctl;
   logic [31:0] b;
   logic [31:0] res;
   assign ctl = decode(bus.opcode);
   assign alu_ctl = ctl.alu_op == ALUOP_SUB   ? ALU_SUB :
                    ctl.alu_op == ALUOP_FUNCT ? funct_ctl(bus.funct) : ALU_ADD;
   assign b = ctl.alu_src ? bus.imm_ext : bus.read_data2;
   always_comb begin
      res = '0;
      case (alu_ctl)
         ALU_ADD: res = bus.src_a + b;
         ALU_SUB: res = bus.src_a - b;
         ALU_AND: res = bus.src_a & b;
         ALU_OR:  res = bus.src_a | b;
         ALU_SLT: res = {31'd0, $signed(bus.src_a) < $signed(b)};
         default: res = '0;
      endcase
   end
   assign bus.reg_write  = ctl.reg_write;
   assign bus.reg_dst    = ctl.reg_dst;
   assign bus.alu_src    = ctl.alu_src;
   assign bus.branch     = ctl.branch;
   assign bus.mem_write  = ctl.mem_write;
   assign bus.mem_to_reg = ctl.mem_to_reg;
   assign bus.jump       = ctl.jump;
   assign bus.alu_ctl    = alu_ctl;
   assign bus.alu_out    = res;
   assign bus.zero       = res == '0;
   assign bus.pc_src     = ctl.branch & (res == '0);
   // Byte address from the ALU; only the word index within the RAM is decoded.
   mips_data_ram #(.MEM_WORDS(MEM_WORDS)) u_ram (
      .clock (clock),
      .reset (reset),
      .we_i  (ctl.mem_write),
      .idx_i (res[AW+1:2]),
      .wd_i  (bus.read_data2),
      .rd_o  (bus.read_data)
   );
endmodule

// File: tb/tb_mips_exec_unit.sv
// tb_mips_exec_unit: directed test-plan steps plus random instructions vs. a table/arithmetic model.
module tb_mips_exec_unit;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   passed = 0;
   logic [31:0] mdl [int];
   mips_exec_unit_if bus ();
   mips_exec_unit #(.MEM_WORDS(64)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic int widx(input logic [31:0] addr);
      return int'((addr % 32'd256) / 32'd4);
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] addr);
      return mdl.exists(widx(addr)) ? mdl[widx(addr)] : 32'd0;
   endfunction

   task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm);
      logic [6:0]  c;
      logic [31:0] bv, r;
      logic [2:0]  ac;
      @(negedge clock);
      bus.opcode = op; bus.funct = fn; bus.src_a = a; bus.read_data2 = b; bus.imm_ext = imm;
      #1;
      case (op)
         6'h00:   c = 7'b1100000;
         6'h23:   c = 7'b1010010;
         6'h2b:   c = 7'b0010100;
         6'h04:   c = 7'b0001000;
         6'h08:   c = 7'b1010000;
         6'h02:   c = 7'b0000001;
         default: c = 7'b0000000;
      endcase
      bv = c[4] ? imm : b;
      ac = 3'b010;
      r  = a + bv;
      if (op == 6'h04) begin
         ac = 3'b110; r = a - bv;
      end else if (op == 6'h00) begin
         case (fn)
            6'h22: begin ac = 3'b110; r = a - bv; end
            6'h24: begin ac = 3'b000; r = a & bv; end
            6'h25: begin ac = 3'b001; r = a | bv; end
            6'h2a: begin ac = 3'b111; r = ($signed(a) < $signed(bv)) ? 32'd1 : 32'd0; end
            default: ;
         endcase
      end
      chk("ctrl", {25'd0, bus.reg_write, bus.reg_dst, bus.alu_src, bus.branch, bus.mem_write,
                   bus.mem_to_reg, bus.jump}, {25'd0, c});
      chk("alu_ctl", {29'd0, bus.alu_ctl}, {29'd0, ac});
      chk("alu_out", bus.alu_out, r);
      chk("zero", {31'd0, bus.zero}, {31'd0, r == 32'd0});
      chk("pc_src", {31'd0, bus.pc_src}, {31'd0, c[3] && r == 32'd0});
      chk("read_data", bus.read_data, mem_rd(r));
      if (c[2] && !reset) mdl[widx(r)] = b;
   endtask

   initial begin
      logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
      logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
      bus.opcode = '0; bus.funct = '0; bus.src_a = '0; bus.read_data2 = '0; bus.imm_ext = '0;
      #2 reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      step(6'h23, 6'h00, 32'd0, 32'd0, 32'd0);
      chk("reset_rd", bus.read_data, 32'd0);
      step(6'h00, 6'h20, 32'd5, 32'd7, 32'd0);
      chk("add_ctl", {29'd0, bus.alu_ctl}, 32'd2);
      chk("add_out", bus.alu_out, 32'd12);
      chk("add_rw_rd", {30'd0, bus.reg_write, bus.reg_dst}, 32'd3);
      step(6'h00, 6'h2a, 32'hFFFF_FFFF, 32'd1, 32'd0);
      chk("slt_neg", bus.alu_out, 32'd1);
      step(6'h00, 6'h2a, 32'd1, 32'hFFFF_FFFF, 32'd0);
      chk("slt_swap", bus.alu_out, 32'd0);
      chk("slt_zero", {31'd0, bus.zero}, 32'd1);
      step(6'h04, 6'h00, 32'h1234, 32'h1234, 32'd0);
      chk("beq_pc_src", {31'd0, bus.pc_src}, 32'd1);
      step(6'h04, 6'h00, 32'h1234, 32'h1235, 32'd0);
      chk("beq_ne_pc_src", {31'd0, bus.pc_src}, 32'd0);
      step(6'h2b, 6'h00, 32'd8, 32'h0, 32'd4);
      step(6'h2b, 6'h00, 32'd8, 32'hDEAD_BEEF, 32'd4);
      chk("sw_mem_write", {31'd0, bus.mem_write}, 32'd1);
      step(6'h23, 6'h00, 32'd8, 32'd0, 32'd4);
      chk("lw_data", bus.read_data, 32'hDEAD_BEEF);
      chk("lw_m2r_src", {30'd0, bus.mem_to_reg, bus.alu_src}, 32'd3);
      step(6'h23, 6'h00, 32'd12 + 32'd256, 32'd0, 32'd0);
      chk("lw_wrap", bus.read_data, 32'hDEAD_BEEF);
      step(6'h3f, 6'h20, 32'd12, 32'h99, 32'd0);
      chk("unk_ctrl", {25'd0, bus.reg_write, bus.reg_dst, bus.alu_src, bus.branch, bus.mem_write,
                       bus.mem_to_reg, bus.jump}, 32'd0);
      step(6'h23, 6'h00, 32'd12, 32'd0, 32'd0);
      chk("unk_no_write", bus.read_data, 32'hDEAD_BEEF);
      step(6'h02, 6'h00, 32'd0, 32'd0, 32'd0);
      chk("j_flags", {29'd0, bus.jump, bus.reg_write, bus.mem_write}, 32'd4);
      step(6'h23, 6'h00, 32'd12, 32'd0, 32'd0);
      #1 reset = 1'b1;
      mdl.delete();
      #1 chk("async_reset_rd", bus.read_data, 32'd0);
      step(6'h2b, 6'h00, 32'd12, 32'h5555_5555, 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      step(6'h23, 6'h00, 32'd12, 32'd0, 32'd0);
      chk("reset_blocks_write", bus.read_data, 32'd0);
      for (int n = 0; n < 300; n++) begin
         int k, f;
         logic [5:0] op, fn;
         logic [31:0] a, b, imm;
         logic [15:0] h;
         k  = $urandom_range(0, 6);
         f  = $urandom_range(0, 5);
         op = (k == 6) ? 6'($urandom) : ops[k];
         fn = (f == 5) ? 6'($urandom) : fns[f];
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
         h  = 16'($urandom);
         imm = {{16{h[15]}}, h};
         if (op == 6'h23 || op == 6'h2b) begin
            a   = $urandom_range(0, 600);
            imm = 32'($urandom_range(0, 64));
         end
         step(op, fn, a, b, imm);
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
